// File: rtl/aer_event_sequencer.sv
// -----------------------------------------------------------------------------
// aer_event_sequencer
//
// Purpose:
//   Pairs row (Y) words from the DVS AER receiver with the column (X) words
//   that follow them. Each pair becomes one timestamped event. Events are
//   queued in a small first-word-fall-through FIFO and handed to the consumer
//   over valid/ready. The block also keeps saturating statistics for protocol
//   errors (orphan words or rows) and for events lost to a full FIFO.
//
// Optional feature (macro AER_EVT_BACKPRESSURE_EN):
//   When defined, rx_hold is a registered request to the receiver to hold off.
//   It is 1 while the FIFO holds FIFO_DEPTH-2 or more events. When undefined,
//   rx_hold is tied to 0 and overflow is handled only by dropping events.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   enable      sequencer enable; when low, the row is closed and words are ignored
//   word_valid  one-cycle pulse per received AER word
//   word_data   AER address word
//   word_xsel   1 = column (X) word, 0 = row (Y) word
//   rx_hold     request to the receiver to withhold ACK
//   evt_valid   event available at the FIFO head
//   evt_ready   consumer accepts the head event
//   evt_x       column address of the head event
//   evt_y       row address of the head event
//   evt_ts      timestamp of the head event
//   fifo_level  current FIFO occupancy
//   orphan_cnt  saturating count of protocol errors
//   drop_cnt    saturating count of events lost to a full FIFO
// -----------------------------------------------------------------------------
module aer_event_sequencer #(
   parameter int AER_W       = 10,
   parameter int TS_W        = 16,
   parameter int FIFO_DEPTH  = 8,
   parameter int ROW_TIMEOUT = 1023
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        word_valid,
   input  logic [AER_W-1:0]            word_data,
   input  logic                        word_xsel,
   output logic                        rx_hold,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [AER_W-1:0]            evt_x,
   output logic [AER_W-1:0]            evt_y,
   output logic [TS_W-1:0]             evt_ts,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [7:0]                  orphan_cnt,
   output logic [7:0]                  drop_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENT_W = 2 * AER_W + TS_W;
   localparam int TMO_W = (ROW_TIMEOUT > 1) ? $clog2(ROW_TIMEOUT) : 1;

   localparam logic [TMO_W-1:0] TMO_LAST = (ROW_TIMEOUT > 0) ? TMO_W'(ROW_TIMEOUT - 1) : '0;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      S_IDLE     = 1'b0,
      S_HAVE_ROW = 1'b1
   } state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e             state_q;
   logic [AER_W-1:0]   row_q;
   logic               has_x_q;
   logic [TMO_W-1:0]   tmo_q;
   logic [TS_W-1:0]    ts_q;
   logic [7:0]         orphan_q;
   logic [7:0]         drop_q;

   logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [LVL_W-1:0]   level_q;
   logic               evt_valid_q;
   logic [ENT_W-1:0]   head_q;

   // ---------------------------------------------------------------------------
   // Word decode
   // ---------------------------------------------------------------------------
   logic               word_acc;
   logic               push_req;
   logic               tmo_hit;
   logic               orphan_inc;
   logic [ENT_W-1:0]   push_ent;

   always_comb begin
      word_acc = enable && word_valid;
      push_req = word_acc && word_xsel && (state_q == S_HAVE_ROW);
      push_ent = {word_data, row_q, ts_q};

      // A quiet cycle with the counter at its last value closes the row.
      tmo_hit = (ROW_TIMEOUT != 0) && enable && !word_valid &&
                (state_q == S_HAVE_ROW) && (tmo_q == TMO_LAST);

      // Orphans: X with no open row, a row superseded before any X,
      // or a row that timed out before any X.
      orphan_inc = 1'b0;
      if (word_acc && (state_q == S_IDLE) && word_xsel)
         orphan_inc = 1'b1;
      if (word_acc && (state_q == S_HAVE_ROW) && !word_xsel && !has_x_q)
         orphan_inc = 1'b1;
      if (tmo_hit && !has_x_q)
         orphan_inc = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Row FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         has_x_q <= 1'b0;
         tmo_q   <= '0;
      end else if (!enable) begin
         state_q <= S_IDLE;
         tmo_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               tmo_q <= '0;
               if (word_valid && !word_xsel) begin
                  row_q   <= word_data;
                  has_x_q <= 1'b0;
                  state_q <= S_HAVE_ROW;
               end
            end
            S_HAVE_ROW: begin
               if (word_valid) begin
                  tmo_q <= '0;
                  if (word_xsel) begin
                     has_x_q <= 1'b1;
                  end else begin
                     row_q   <= word_data;
                     has_x_q <= 1'b0;
                  end
               end else if (tmo_hit) begin
                  tmo_q   <= '0;
                  state_q <= S_IDLE;
               end else if (ROW_TIMEOUT != 0) begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               tmo_q   <= '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Timestamp and statistics
   // ---------------------------------------------------------------------------
   logic pop;
   logic full;
   logic push_ok;
   logic drop_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q     <= '0;
         orphan_q <= '0;
         drop_q   <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
         if (orphan_inc)
            orphan_q <= sat_inc8(orphan_q);
         if (drop_inc)
            drop_q <= sat_inc8(drop_q);
      end
   end

   // ---------------------------------------------------------------------------
   // Event FIFO
   // ---------------------------------------------------------------------------
   logic [PTR_W-1:0] wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_d;
   logic [LVL_W-1:0] level_d;
   logic [ENT_W-1:0] head_d;

   always_comb begin
      pop      = evt_valid_q && evt_ready;
      full     = (level_q == LVL_FULL);
      // A pop frees the slot this cycle, so a full FIFO still accepts a push.
      push_ok  = push_req && (!full || pop);
      drop_inc = push_req && full && !pop;

      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);

      // The next head may be the entry being written on this same edge.
      if (push_ok && (wr_ptr_q == rd_ptr_d))
         head_d = push_ent;
      else
         head_d = mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_ptr_q] <= push_ent;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         evt_valid_q <= 1'b0;
         head_q      <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         evt_valid_q <= (level_d != '0);
         // Head outputs hold their last value while the FIFO is empty.
         if (level_d != '0)
            head_q <= head_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Receiver flow control
   // ---------------------------------------------------------------------------
`ifdef AER_EVT_BACKPRESSURE_EN
   logic rx_hold_q;

   always_ff @(posedge clk) begin
      if (rst)
         rx_hold_q <= 1'b0;
      else
         rx_hold_q <= (level_q >= LVL_W'(FIFO_DEPTH - 2));
   end

   assign rx_hold = rx_hold_q;
`else
   assign rx_hold = 1'b0;
`endif

   assign evt_valid  = evt_valid_q;
   assign evt_x      = head_q[ENT_W-1 -: AER_W];
   assign evt_y      = head_q[TS_W +: AER_W];
   assign evt_ts     = head_q[TS_W-1:0];
   assign fifo_level = level_q;
   assign orphan_cnt = orphan_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_aer_event_sequencer.sv
module tb_aer_event_sequencer;

   localparam int AER_W = 10;
   localparam int TS_W  = 16;
   localparam int DEPTH = 8;
   localparam int TMO   = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             enable = 1'b1;
   logic             word_valid = 1'b0;
   logic [AER_W-1:0] word_data = '0;
   logic             word_xsel = 1'b0;
   logic             evt_ready = 1'b1;
   logic             rx_hold;
   logic             evt_valid;
   logic [AER_W-1:0] evt_x;
   logic [AER_W-1:0] evt_y;
   logic [TS_W-1:0]  evt_ts;
   logic [3:0]       fifo_level;
   logic [7:0]       orphan_cnt;
   logic [7:0]       drop_cnt;

   aer_event_sequencer #(
      .AER_W(AER_W), .TS_W(TS_W), .FIFO_DEPTH(DEPTH), .ROW_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .word_valid(word_valid), .word_data(word_data), .word_xsel(word_xsel),
      .rx_hold(rx_hold), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_x(evt_x), .evt_y(evt_y), .evt_ts(evt_ts),
      .fifo_level(fifo_level), .orphan_cnt(orphan_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AER_W-1:0] x;
      logic [AER_W-1:0] y;
      logic [TS_W-1:0]  ts;
   } evt_t;

   evt_t expq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state: an open row, whether it has paired, quiet cycles.
   bit               row_open   = 0;
   logic [AER_W-1:0] row_addr   = '0;
   bit               row_paired = 0;
   int               quiet      = 0;
   logic [TS_W-1:0]  m_ts       = '0;
   int               m_level    = 0;
   int               m_orphan   = 0;
   int               m_drop     = 0;
   bit               m_hold     = 0;
   evt_t             last_head  = '0;

   function automatic int sat8(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model, advanced once per clock edge.
   always @(posedge clk) begin
      bit pop;
      bit pushed;
      if (rst) begin
         row_open = 0; row_addr = '0; row_paired = 0; quiet = 0;
         m_ts = '0; m_level = 0; m_orphan = 0; m_drop = 0; m_hold = 0;
         last_head = '0;
         expq.delete();
      end else begin
         pop    = evt_ready && (m_level > 0);
         pushed = 0;
`ifdef AER_EVT_BACKPRESSURE_EN
         m_hold = (m_level >= DEPTH - 2);
`else
         m_hold = 0;
`endif
         if (!enable) begin
            row_open = 0;
            quiet    = 0;
         end else if (word_valid) begin
            quiet = 0;
            if (word_xsel) begin
               if (row_open) begin
                  row_paired = 1;
                  pushed     = 1;
               end else begin
                  m_orphan++;
               end
            end else begin
               if (row_open && !row_paired) m_orphan++;
               row_open   = 1;
               row_addr   = word_data;
               row_paired = 0;
            end
         end else if (row_open) begin
            quiet++;
            if (quiet == TMO) begin
               if (!row_paired) m_orphan++;
               row_open = 0;
               quiet    = 0;
            end
         end
         if (pushed) begin
            if (m_level - int'(pop) < DEPTH) begin
               expq.push_back('{x: word_data, y: row_addr, ts: m_ts});
               m_level++;
            end else begin
               m_drop++;
            end
         end
         if (pop) m_level--;
         m_ts = m_ts + 16'd1;
      end
   end

   // Monitor: compares every cycle, pops the scoreboard when the consumer accepts.
   always @(negedge clk) begin
      chk("evt_valid", 64'(evt_valid), 64'(m_level > 0));
      chk("fifo_level", 64'(fifo_level), 64'(m_level));
      chk("orphan_cnt", 64'(orphan_cnt), 64'(sat8(m_orphan)));
      chk("drop_cnt", 64'(drop_cnt), 64'(sat8(m_drop)));
      chk("rx_hold", 64'(rx_hold), 64'(m_hold));
      if (expq.size() > 0) begin
         chk("evt_x", 64'(evt_x), 64'(expq[0].x));
         chk("evt_y", 64'(evt_y), 64'(expq[0].y));
         chk("evt_ts", 64'(evt_ts), 64'(expq[0].ts));
         last_head = expq[0];
         if (evt_ready) void'(expq.pop_front());
      end else begin
         chk("hold_x", 64'(evt_x), 64'(last_head.x));
         chk("hold_y", 64'(evt_y), 64'(last_head.y));
         chk("hold_ts", 64'(evt_ts), 64'(last_head.ts));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         word_valid = 1'b0;
      end
   endtask

   task automatic send(input bit xs, input logic [AER_W-1:0] d);
      @(posedge clk); #1;
      word_valid = 1'b1; word_xsel = xs; word_data = d;
      @(posedge clk); #1;
      word_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; word_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int quiet_left;
      int guard;
      quiet_left = 0;

      // Reset state
      do_reset();
      chk("rst_valid", 64'(evt_valid), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_orphan", 64'(orphan_cnt), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_hold", 64'(rx_hold), 64'd0);
      chk("rst_evt_x", 64'(evt_x), 64'd0);

      // Basic pair, one-cycle latency
      send(0, 10'h012); idle(3); send(1, 10'h034);
      chk("t1_valid", 64'(evt_valid), 64'd1);
      chk("t1_x", 64'(evt_x), 64'h034);
      chk("t1_y", 64'(evt_y), 64'h012);

      // Column burst on one row
      send(0, 10'h005); send(1, 10'h001); send(1, 10'h002); send(1, 10'h003);
      idle(4);
      chk("t2_orphan", 64'(orphan_cnt), 64'd0);

      // Orphan X and superseded row
      do_reset();
      send(1, 10'h010); send(0, 10'h001); send(0, 10'h002); send(1, 10'h007);
      chk("t3_orphan", 64'(orphan_cnt), 64'd2);
      chk("t3_x", 64'(evt_x), 64'h007);
      chk("t3_y", 64'(evt_y), 64'h002);
      idle(3);

      // Row timeout then orphan X
      do_reset();
      send(0, 10'h003); idle(20); send(1, 10'h004); idle(2);
      chk("t4_orphan", 64'(orphan_cnt), 64'd2);
      chk("t4_level", 64'(fifo_level), 64'd0);

      // Overflow with a stalled consumer, then drain
      do_reset();
      evt_ready = 1'b0;
      send(0, 10'h00A);
      for (int i = 0; i < 10; i++) send(1, 10'(i + 1));
      chk("t5_level", 64'(fifo_level), 64'd8);
      chk("t5_drop", 64'(drop_cnt), 64'd2);
`ifdef AER_EVT_BACKPRESSURE_EN
      chk("t5_hold", 64'(rx_hold), 64'd1);
`else
      chk("t5_hold", 64'(rx_hold), 64'd0);
`endif
      evt_ready = 1'b1;
      idle(10);
      chk("t5_drained", 64'(fifo_level), 64'd0);
      chk("t5_hold_rel", 64'(rx_hold), 64'd0);

      // Full FIFO: push and pop together
      do_reset();
      evt_ready = 1'b0;
      send(0, 10'h0C0);
      for (int i = 0; i < 8; i++) send(1, 10'(i + 16));
      @(posedge clk); #1;
      evt_ready = 1'b1; word_valid = 1'b1; word_xsel = 1'b1; word_data = 10'h3FF;
      @(posedge clk); #1;
      evt_ready = 1'b0; word_valid = 1'b0;
      chk("t6_level", 64'(fifo_level), 64'd8);
      chk("t6_drop", 64'(drop_cnt), 64'd0);
      evt_ready = 1'b1;
      idle(3);
      evt_ready = 1'b0;
      chk("t6_level5", 64'(fifo_level), 64'd5);
      do_reset();
      chk("t6_rst_valid", 64'(evt_valid), 64'd0);
      chk("t6_rst_level", 64'(fifo_level), 64'd0);
      chk("t6_rst_orphan", 64'(orphan_cnt), 64'd0);
      chk("t6_rst_drop", 64'(drop_cnt), 64'd0);
      evt_ready = 1'b1;

      // Enable low closes the row and ignores words
      send(0, 10'h0AA);
      @(posedge clk); #1; enable = 1'b0;
      send(1, 10'h0BB);
      enable = 1'b1;
      send(1, 10'h0BC); idle(2);
      chk("en_orphan", 64'(orphan_cnt), 64'd1);
      chk("en_level", 64'(fifo_level), 64'd0);

      // Counter saturation
      do_reset();
      for (int i = 0; i < 260; i++) send(1, 10'(i));
      chk("sat_orphan", 64'(orphan_cnt), 64'd255);
      evt_ready = 1'b0;
      send(0, 10'h111);
      for (int i = 0; i < 8 + 260; i++) send(1, 10'(i));
      chk("sat_drop", 64'(drop_cnt), 64'd255);
      evt_ready = 1'b1;
      idle(10);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rst       = ($urandom_range(0, 699) == 0);
         enable    = ($urandom_range(0, 39) != 0);
         evt_ready = ($urandom_range(0, 9) < ((c < 1500) ? 2 : 6));
         if (quiet_left > 0) begin
            quiet_left--;
            word_valid = 1'b0;
         end else begin
            word_valid = ($urandom_range(0, 9) < 4);
            word_xsel  = ($urandom_range(0, 9) < 7);
            word_data  = 10'($urandom);
            if ($urandom_range(0, 99) == 0) quiet_left = $urandom_range(10, 25);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0; enable = 1'b1; word_valid = 1'b0; evt_ready = 1'b1;
      guard = 0;
      while (fifo_level != 0 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("final_drain", 64'(fifo_level), 64'd0);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
